ntt_butterfly: RTL and testbench



---
 rtl/ntt_pkg.sv | 28 ++
 rtl/ntt_butterfly_if.sv | 26 ++
 rtl/mod_add.sv | 14 +
 rtl/mod_mul_barrett.sv | 57 +++++
 rtl/ntt_butterfly.sv | 107 ++++++++++
 tb/tb_ntt_butterfly.sv | 211 +++++++++++++++++++++
 6 files changed

// File: rtl/ntt_pkg.sv
// Shared constants, residue/product types and the modular subtract helper
// for the NTT butterfly datapath (modulus 12289, 14-bit residues).
package ntt_pkg;
  localparam int DATA_WIDTH  = 14;
  localparam int M           = 12289;
  localparam int BARRETT_K   = 28;
  localparam int BARRETT_MU  = 21843;   // floor(2^28 / M)
  localparam int PROD_WIDTH  = 28;
  localparam int QUOT_WIDTH  = 15;      // q < BARRETT_MU < 2^15
  localparam int BMUL_WIDTH  = PROD_WIDTH + QUOT_WIDTH;

  typedef logic [DATA_WIDTH-1:0] residue_t;
  typedef logic [PROD_WIDTH-1:0] product_t;

  localparam logic [DATA_WIDTH:0] M_W = (DATA_WIDTH+1)'(M);
  localparam product_t            M_P = PROD_WIDTH'(M);

  // x - y mod M for x, y < M: a borrow out of the top bit means the raw
  // difference went negative, so M is added back. Equal inputs give 0.
  function automatic residue_t mod_sub(input residue_t x, input residue_t y);
    logic [DATA_WIDTH:0] diff;
    diff = {1'b0, x} - {1'b0, y};
    if (diff[DATA_WIDTH]) begin
      diff = diff + M_W;
    end
    return diff[DATA_WIDTH-1:0];
  endfunction
endpackage

// File: rtl/ntt_butterfly_if.sv
// Sample bus for one butterfly unit.
// Handshake: there is no backpressure. On a rising clk edge with en=1 the
// sample on a_in/b_in/w_in/mode is captured as valid when in_valid=1, or as a
// bubble when in_valid=0. With en=0 nothing moves. out_valid=1 marks a_out and
// b_out as a completed butterfly; every enabled edge presents the next slot.
interface ntt_butterfly_if import ntt_pkg::*; ();
  logic     en;
  logic     in_valid;
  logic     mode;
  residue_t a_in;
  residue_t b_in;
  residue_t w_in;
  logic     out_valid;
  residue_t a_out;
  residue_t b_out;

  modport master (
    output en, in_valid, mode, a_in, b_in, w_in,
    input  out_valid, a_out, b_out
  );

  modport slave (
    input  en, in_valid, mode, a_in, b_in, w_in,
    output out_valid, a_out, b_out
  );
endinterface

// File: rtl/mod_add.sv
// Modular adder: (x + y) mod M for x, y < M. A sum of exactly M folds to 0.
module mod_add import ntt_pkg::*; (
  input  residue_t x,
  input  residue_t y,
  output residue_t sum
);
  logic [DATA_WIDTH:0] raw;

  // One conditional subtract suffices since x + y < 2M.
  always_comb begin
    raw = {1'b0, x} + {1'b0, y};
    sum = residue_t'((raw >= M_W) ? (raw - M_W) : raw);
  end
endmodule

// File: rtl/mod_mul_barrett.sv
// Two-stage pipelined modular multiplier with Barrett reduction.
// Stage A registers p = x*y and the quotient estimate q = (p*mu) >> 28.
// Stage B registers r = p - q*M corrected into 0..M-1.
module mod_mul_barrett import ntt_pkg::*; (
  input  logic     clk,
  input  logic     rst,
  input  logic     en,
  input  logic     in_valid,
  input  residue_t x,
  input  residue_t y,
  output logic     out_valid,
  output residue_t r
);
  product_t                p_d;
  product_t                p_q;
  logic [BMUL_WIDTH-1:0]   pmu;
  logic [QUOT_WIDTH-1:0]   q_d;
  logic [QUOT_WIDTH-1:0]   q_q;
  logic                    a_valid;
  product_t                t;
  residue_t                r_d;

  // Product and Barrett quotient; (M-1)^2 < 2^28 so p never overflows.
  always_comb begin
    p_d = product_t'(x) * product_t'(y);
    pmu = BMUL_WIDTH'(p_d) * BMUL_WIDTH'(BARRETT_MU);
    q_d = QUOT_WIDTH'(pmu >> BARRETT_K);
  end

  // q underestimates floor(p/M) by at most 2, so two corrective subtracts.
  always_comb begin
    t = p_q - product_t'(q_q) * M_P;
    if (t >= M_P) t = t - M_P;
    if (t >= M_P) t = t - M_P;
    r_d = residue_t'(t);
  end

  // Valid side-channel: cleared by reset, frozen when en=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid   <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      a_valid   <= in_valid;
      out_valid <= a_valid;
    end
  end

  // Data registers advance only with en.
  always_ff @(posedge clk) begin
    if (en) begin
      p_q <= p_d;
      q_q <= q_d;
      r   <= r_d;
    end
  end
endmodule

// File: rtl/ntt_butterfly.sv
// Four-stage radix-2 NTT butterfly over Z_12289.
// mode=0 (CT): a' = a + w*b, b' = a - w*b.
// mode=1 (GS): a' = a + b,   b' = (a - b) * w.
// Both modes share the multiplier; the non-multiplied operand (a for CT,
// a+b for GS) rides a delay line so either mode emits on the same cycle.
module ntt_butterfly import ntt_pkg::*; (
  input logic           clk,
  input logic           rst,
  ntt_butterfly_if.slave bus
);
  residue_t s_d;
  residue_t d_d;
  residue_t x_d;
  residue_t pass_d;

  logic     s1_valid;
  logic     s1_mode;
  residue_t s1_pass;
  residue_t s1_x;
  residue_t s1_w;

  logic     s2_mode;
  residue_t s2_pass;
  logic     s3_mode;
  residue_t s3_pass;

  logic     s3_valid;
  residue_t s3_r;

  residue_t ct_sum;
  residue_t ct_diff;
  residue_t a_next;
  residue_t b_next;

  mod_add u_add_in (
    .x   (bus.a_in),
    .y   (bus.b_in),
    .sum (s_d)
  );

  // Select the multiplier operand and the pass-through operand per mode.
  always_comb begin
    d_d    = mod_sub(bus.a_in, bus.b_in);
    x_d    = bus.mode ? d_d : bus.b_in;
    pass_d = bus.mode ? s_d : bus.a_in;
  end

  // S1 valid: cleared by reset, frozen when en=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (bus.en) begin
      s1_valid <= bus.in_valid;
    end
  end

  // S1 data capture plus the mode/pass delay line matching the multiplier.
  always_ff @(posedge clk) begin
    if (bus.en) begin
      s1_mode <= bus.mode;
      s1_pass <= pass_d;
      s1_x    <= x_d;
      s1_w    <= bus.w_in;
      s2_mode <= s1_mode;
      s2_pass <= s1_pass;
      s3_mode <= s2_mode;
      s3_pass <= s2_pass;
    end
  end

  mod_mul_barrett u_mul (
    .clk       (clk),
    .rst       (rst),
    .en        (bus.en),
    .in_valid  (s1_valid),
    .x         (s1_w),
    .y         (s1_x),
    .out_valid (s3_valid),
    .r         (s3_r)
  );

  mod_add u_add_ct (
    .x   (s3_pass),
    .y   (s3_r),
    .sum (ct_sum)
  );

  // S4 combine: CT adds/subtracts the reduced product; GS forwards s and r.
  always_comb begin
    ct_diff = mod_sub(s3_pass, s3_r);
    a_next  = s3_mode ? s3_pass : ct_sum;
    b_next  = s3_mode ? s3_r    : ct_diff;
  end

  // Output registers: reset clears them regardless of en.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.a_out     <= '0;
      bus.b_out     <= '0;
    end else if (bus.en) begin
      bus.out_valid <= s3_valid;
      bus.a_out     <= a_next;
      bus.b_out     <= b_next;
    end
  end
endmodule

// File: tb/tb_ntt_butterfly.sv
// Self-checking bench for ntt_butterfly: directed vectors with hand-computed
// results, stall and reset scenarios, then a randomized stream against a
// plain-modulo reference model.
module tb_ntt_butterfly;
  localparam int MOD = 12289;
  localparam int W   = 28;

  logic clk;
  logic rst;

  ntt_butterfly_if bus ();

  ntt_butterfly dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           cap_q[$];
  int           compared   = 0;
  int           mismatched = 0;
  int           en_count   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic md, input int a, input int b, input int w);
    int ea;
    int eb;
    if (!md) begin
      ea = (a + w * b) % MOD;
      eb = (a - (w * b) % MOD + MOD) % MOD;
    end else begin
      ea = (a + b) % MOD;
      eb = (((a - b + MOD) % MOD) * w) % MOD;
    end
    return {ea[13:0], eb[13:0]};
  endfunction

  // One clock: inputs were set at the previous falling edge; outputs are
  // sampled at the next falling edge. Only enabled, non-reset edges produce
  // a new output slot.
  task automatic tick();
    logic         was_en;
    logic         was_rst;
    logic [W-1:0] e;
    int           c;
    was_en  = bus.en;
    was_rst = rst;
    @(posedge clk);
    @(negedge clk);
    if (was_en && !was_rst) begin
      en_count++;
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          c = cap_q.pop_front();
          check("a_out", 32'(bus.a_out), 32'(e[27:14]));
          check("b_out", 32'(bus.b_out), 32'(e[13:0]));
          check("latency", 32'(en_count - c), 32'd3);
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic md, input int a, input int b, input int w,
                      input int ea, input int eb);
    bus.en       = 1'b1;
    bus.in_valid = 1'b1;
    bus.mode     = md;
    bus.a_in     = 14'(a);
    bus.b_in     = 14'(b);
    bus.w_in     = 14'(w);
    exp_q.push_back({ea[13:0], eb[13:0]});
    cap_q.push_back(en_count + 1);
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.en       = 1'b1;
      bus.in_valid = 1'b0;
      tick();
    end
  endtask

  task automatic rand_operand(output int v);
    int sel;
    sel = int'($urandom_range(0, 7));
    if (sel == 0)      v = 0;
    else if (sel == 1) v = MOD - 1;
    else               v = int'($urandom_range(0, MOD - 1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.in_valid = 1'b0;
    bus.mode     = 1'b0;
    bus.a_in     = '0;
    bus.b_in     = '0;
    bus.w_in     = '0;
    tick();
    tick();
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_a", 32'(bus.a_out), 32'd0);
    check("rst_b", 32'(bus.b_out), 32'd0);
    rst = 1'b0;

    // 1: CT basic with latency probing
    send(1'b0, 1, 2, 3, 7, 12284);
    idle(1);
    check("t1_valid_k1", 32'(bus.out_valid), 32'd0);
    idle(1);
    check("t1_valid_k2", 32'(bus.out_valid), 32'd0);
    idle(1);
    check("t1_valid_k3", 32'(bus.out_valid), 32'd1);
    idle(2);

    // 2: CT wrap and zero
    send(1'b0, 12288, 12288, 12288, 0, 12287);
    send(1'b0, 0, 0, 5, 0, 0);
    // 3: GS, back-to-back mode mixing, sum == M, zero difference
    send(1'b1, 5, 10, 2, 15, 12279);
    send(1'b1, 12288, 1, 7, 0, 12275);
    send(1'b0, 12288, 1, 1, 0, 12287);
    send(1'b1, 7, 7, 9, 14, 0);
    send(1'b0, 3, 0, 12288, 3, 3);
    idle(5);

    // 4: stall with a known result held on the outputs
    send(1'b0, 100, 200, 3, 700, 11789);
    idle(1);
    send(1'b0, 2, 3, 4, 14, 12279);
    send(1'b0, 12000, 5000, 3, 2422, 9289);
    for (int i = 0; i < 3; i++) begin
      bus.en       = 1'b0;
      bus.in_valid = 1'b1;
      bus.mode     = 1'(i);
      bus.a_in     = 14'(1000 + i);
      bus.b_in     = 14'(2000 + i);
      bus.w_in     = 14'(3000 + i);
      tick();
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_a", 32'(bus.a_out), 32'd700);
      check("stall_b", 32'(bus.b_out), 32'd11789);
    end
    send(1'b0, 0, 1, 1, 1, 12288);
    idle(5);
    check("t4_drain", 32'(exp_q.size()), 32'd0);

    // 5: reset mid-stream (with en low, which must not block the reset)
    send(1'b0, 1, 1, 1, 2, 0);
    send(1'b0, 2, 2, 2, 6, 12287);
    send(1'b1, 4, 1, 3, 5, 9);
    send(1'b1, 9, 4, 2, 13, 10);
    rst    = 1'b1;
    bus.en = 1'b0;
    tick();
    check("t5_valid", 32'(bus.out_valid), 32'd0);
    check("t5_a", 32'(bus.a_out), 32'd0);
    check("t5_b", 32'(bus.b_out), 32'd0);
    exp_q.delete();
    cap_q.delete();
    rst = 1'b0;
    idle(8);

    // 6: random mixed stream with random bubbles and stalls
    for (int n = 0; n < 2000; n++) begin
      int a;
      int b;
      int w;
      logic md;
      rand_operand(a);
      rand_operand(b);
      rand_operand(w);
      md           = 1'($urandom_range(0, 1));
      bus.en       = ($urandom_range(0, 3) != 0);
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.mode     = md;
      bus.a_in     = 14'(a);
      bus.b_in     = 14'(b);
      bus.w_in     = 14'(w);
      if (bus.en && bus.in_valid) begin
        exp_q.push_back(model(md, a, b, w));
        cap_q.push_back(en_count + 1);
      end
      tick();
    end
    idle(6);
    check("final_drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
